// File: rtl/demux_1x2_stream.sv
// -----------------------------------------------------------------------------
// demux_1x2_stream
//
// Registered 1-to-2 stream demultiplexer. A single producer stream is routed to
// one of two consumer streams by in_select (0 -> out1, 1 -> out2). Each output
// owns a 2-entry FIFO, so a stalled consumer only blocks traffic addressed to
// it. Ordering is preserved per output; nothing is guaranteed across outputs.
//
// Optional feature macro: DEMUX_STATS_EN
//   When defined, adds out1_beats/out2_beats: 16-bit saturating counts of
//   beats delivered (pop handshakes) on each output.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     producer has a beat
//   in_ready     beat accepted when in_valid && in_ready
//   in_select    route select (sampled only on a push)
//   in_data      payload
//   out1_valid   out1 head entry valid
//   out1_ready   consumer 1 accepts head entry
//   out1_data    out1 head payload (registered)
//   out2_valid   out2 head entry valid
//   out2_ready   consumer 2 accepts head entry
//   out2_data    out2 head payload (registered)
//   out1_beats   [DEMUX_STATS_EN] beats delivered on out1
//   out2_beats   [DEMUX_STATS_EN] beats delivered on out2
// -----------------------------------------------------------------------------
module demux_1x2_stream #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_select,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out2_valid,
  input  logic                  out2_ready,
  output logic [DATA_WIDTH-1:0] out2_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]           out1_beats,
  output logic [15:0]           out2_beats
`endif
);

  // Index 0 is the out1 FIFO, index 1 is the out2 FIFO.
  logic [DATA_WIDTH-1:0] r_mem     [2][2];
  logic                  r_rd_ptr  [2];
  logic                  r_wr_ptr  [2];
  logic [1:0]            r_count   [2];

  logic                  w_out_ready [2];
  logic                  w_push      [2];
  logic                  w_pop       [2];
  logic                  w_not_full  [2];

  assign w_out_ready[0] = out1_ready;
  assign w_out_ready[1] = out2_ready;

  always_comb begin
    for (int unsigned f = 0; f < 2; f++) begin
      w_not_full[f] = (r_count[f] < 2'd2);
    end
  end

  // in_ready looks only at the selected FIFO's occupancy. A full FIFO refuses
  // the push even if it is being popped this cycle (no pass-through), which
  // keeps in_ready free of any path from outN_ready. An unknown select falls
  // into the final branch and refuses the beat.
  always_comb begin
    in_ready = 1'b0;
    if (in_select == 1'b0) begin
      in_ready = w_not_full[0];
    end else if (in_select == 1'b1) begin
      in_ready = w_not_full[1];
    end else begin
      in_ready = 1'b0;
    end
  end

  always_comb begin
    for (int unsigned f = 0; f < 2; f++) begin
      w_push[f] = 1'b0;
      w_pop[f]  = 1'b0;
      w_push[f] = in_valid && in_ready && (in_select == (f != 0));
      w_pop[f]  = (r_count[f] != 2'd0) && w_out_ready[f];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned f = 0; f < 2; f++) begin
        r_rd_ptr[f] <= 1'b0;
        r_wr_ptr[f] <= 1'b0;
        r_count[f]  <= 2'd0;
        for (int unsigned e = 0; e < 2; e++) begin
          r_mem[f][e] <= '0;
        end
      end
    end else begin
      for (int unsigned f = 0; f < 2; f++) begin
        if (w_push[f]) begin
          r_mem[f][r_wr_ptr[f]] <= in_data;
          r_wr_ptr[f]           <= r_wr_ptr[f] + 1'b1;
        end
        if (w_pop[f]) begin
          r_rd_ptr[f] <= r_rd_ptr[f] + 1'b1;
        end
        // Push and pop together leave the count unchanged.
        case ({w_push[f], w_pop[f]})
          2'b10:   r_count[f] <= r_count[f] + 2'd1;
          2'b01:   r_count[f] <= r_count[f] - 2'd1;
          default: r_count[f] <= r_count[f];
        endcase
      end
    end
  end

  assign out1_valid = (r_count[0] != 2'd0);
  assign out2_valid = (r_count[1] != 2'd0);
  assign out1_data  = r_mem[0][r_rd_ptr[0]];
  assign out2_data  = r_mem[1][r_rd_ptr[1]];

`ifdef DEMUX_STATS_EN
  logic [15:0] r_beats [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned f = 0; f < 2; f++) begin
        r_beats[f] <= '0;
      end
    end else begin
      for (int unsigned f = 0; f < 2; f++) begin
        if (w_pop[f] && (r_beats[f] != '1)) begin
          r_beats[f] <= r_beats[f] + 16'd1;
        end
      end
    end
  end

  assign out1_beats = r_beats[0];
  assign out2_beats = r_beats[1];
`endif

  // A beat offered with an unknown route cannot be steered anywhere.
  a_select_known: assert property (@(posedge clk) disable iff (!rst_n)
    in_valid |-> !$isunknown(in_select));

endmodule

// File: tb/tb_demux_1x2_stream.sv
module tb_demux_1x2_stream;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_select = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out1_valid;
  logic          out1_ready = 1'b0;
  logic [DW-1:0] out1_data;
  logic          out2_valid;
  logic          out2_ready = 1'b0;
  logic [DW-1:0] out2_data;
`ifdef DEMUX_STATS_EN
  logic [15:0]   out1_beats;
  logic [15:0]   out2_beats;
`endif

  demux_1x2_stream #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_select  (in_select),
    .in_data    (in_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out2_data  (out2_data)
`ifdef DEMUX_STATS_EN
    ,
    .out1_beats (out1_beats),
    .out2_beats (out2_beats)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard: expected beats are pushed by the tasks when the bench sees its
  // own push accepted; observed beats are collected by the monitor below.
  logic [DW-1:0] exp1 [$];
  logic [DW-1:0] exp2 [$];
  logic [DW-1:0] obs1 [$];
  logic [DW-1:0] obs2 [$];
  bit            mon_en = 1'b1;

  logic          p_v = 1'b0;
  logic          p_acc = 1'b0;
  logic          p_sel = 1'b0;
  logic [DW-1:0] p_d = '0;

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (out1_valid && out1_ready) obs1.push_back(out1_data);
      if (out2_valid && out2_ready) obs2.push_back(out2_data);
    end
    // Producer rule: a pending beat keeps its data and select until accepted.
    if (rst_n && p_v && !p_acc && in_valid) begin
      checks++;
      if (in_data !== p_d || in_select !== p_sel) begin
        errors++;
        $display("FAIL protocol_hold got=%0h/%0b exp=%0h/%0b", in_data, in_select, p_d, p_sel);
      end
    end
    p_v   = rst_n && in_valid;
    p_acc = in_valid && in_ready;
    p_sel = in_select;
    p_d   = in_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_select = 1'b0; in_data = '0;
    out1_ready = 1'b0; out2_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL rst_v1 got=%0b exp=0", out1_valid); end
    checks++; if (out2_valid !== 1'b0) begin errors++; $display("FAIL rst_v2 got=%0b exp=0", out2_valid); end
    checks++; if (out1_data !== '0) begin errors++; $display("FAIL rst_d1 got=%0h exp=0", out1_data); end
    checks++; if (out2_data !== '0) begin errors++; $display("FAIL rst_d2 got=%0h exp=0", out2_data); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_single();
    out1_ready = 1'b1; out2_ready = 1'b0;
    tick();
    in_valid = 1'b1; in_select = 1'b0; in_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%0b exp=1", in_ready); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL single_pre_v1 got=%0b exp=0", out1_valid); end
    if (in_ready) exp1.push_back(in_data);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out1_valid !== 1'b1) begin errors++; $display("FAIL single_v1 got=%0b exp=1", out1_valid); end
    checks++; if (out1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_d1 got=%0h exp=deadbeef", out1_data); end
    checks++; if (out2_valid !== 1'b0) begin errors++; $display("FAIL single_v2 got=%0b exp=0", out2_valid); end
    @(negedge clk);
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL single_drain_v1 got=%0b exp=0", out1_valid); end
    checks++; if (obs1.size() !== exp1.size()) begin errors++; $display("FAIL single_count got=%0d exp=%0d", obs1.size(), exp1.size()); end
    while (exp1.size() > 0 && obs1.size() > 0) begin
      logic [DW-1:0] e, o;
      e = exp1.pop_front(); o = obs1.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL single_sb1 got=%0h exp=%0h", o, e); end
    end
    exp1.delete(); obs1.delete();
  endtask

  task automatic test_stall();
    logic [DW-1:0] a [3];
    a[0] = 32'hA0000001; a[1] = 32'hA0000002; a[2] = 32'hA0000003;
    out1_ready = 1'b1; out2_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid = 1'b1; in_select = 1'b1; in_data = a[i];
      @(negedge clk);
      checks++;
      if (in_ready !== (i < 2)) begin errors++; $display("FAIL stall_ready%0d got=%0b exp=%0b", i, in_ready, (i < 2)); end
      if (in_ready) exp2.push_back(in_data);
    end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_hold_ready got=%0b exp=0", in_ready); end
    checks++; if (out2_data !== a[0]) begin errors++; $display("FAIL stall_head2 got=%0h exp=%0h", out2_data, a[0]); end
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_select = 1'b0; in_data = 32'hB0000001;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_b1_ready got=%0b exp=1", in_ready); end
    if (in_ready) exp1.push_back(in_data);
    tick();
    in_valid = 1'b0;
    tick();
    out2_ready = 1'b1;
    for (int t = 0; t < 50 && (obs1.size() < exp1.size() || obs2.size() < exp2.size()); t++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++; if (obs1.size() !== exp1.size()) begin errors++; $display("FAIL stall_count1 got=%0d exp=%0d", obs1.size(), exp1.size()); end
    checks++; if (obs2.size() !== exp2.size()) begin errors++; $display("FAIL stall_count2 got=%0d exp=%0d", obs2.size(), exp2.size()); end
    while (exp1.size() > 0 && obs1.size() > 0) begin
      logic [DW-1:0] e, o;
      e = exp1.pop_front(); o = obs1.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stall_sb1 got=%0h exp=%0h", o, e); end
    end
    while (exp2.size() > 0 && obs2.size() > 0) begin
      logic [DW-1:0] e, o;
      e = exp2.pop_front(); o = obs2.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stall_sb2 got=%0h exp=%0h", o, e); end
    end
    exp1.delete(); exp2.delete(); obs1.delete(); obs2.delete();
  endtask

  task automatic test_stream();
    int accepted;
    accepted = 0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      in_valid = 1'b1; in_select = 1'($urandom_range(0, 1)); in_data = $urandom();
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got=%0b exp=1", i, in_ready); end
      if (in_ready) begin
        accepted++;
        if (in_select) exp2.push_back(in_data); else exp1.push_back(in_data);
      end
    end
    tick();
    in_valid = 1'b0;
    checks++; if (accepted !== 100) begin errors++; $display("FAIL stream_accepted got=%0d exp=100", accepted); end
    for (int t = 0; t < 50 && (obs1.size() < exp1.size() || obs2.size() < exp2.size()); t++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++; if (obs1.size() !== exp1.size()) begin errors++; $display("FAIL stream_count1 got=%0d exp=%0d", obs1.size(), exp1.size()); end
    checks++; if (obs2.size() !== exp2.size()) begin errors++; $display("FAIL stream_count2 got=%0d exp=%0d", obs2.size(), exp2.size()); end
    while (exp1.size() > 0 && obs1.size() > 0) begin
      logic [DW-1:0] e, o;
      e = exp1.pop_front(); o = obs1.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stream_sb1 got=%0h exp=%0h", o, e); end
    end
    while (exp2.size() > 0 && obs2.size() > 0) begin
      logic [DW-1:0] e, o;
      e = exp2.pop_front(); o = obs2.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stream_sb2 got=%0h exp=%0h", o, e); end
    end
    exp1.delete(); exp2.delete(); obs1.delete(); obs2.delete();
  endtask

  task automatic test_full_pop();
    out1_ready = 1'b0; out2_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      in_valid = 1'b1; in_select = 1'b0; in_data = 32'hC0000001 + i;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_fill%0d got=%0b exp=1", i, in_ready); end
      if (in_ready) exp1.push_back(in_data);
    end
    tick();
    in_valid = 1'b1; in_select = 1'b0; in_data = 32'hC0000003; out1_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_refuse got=%0b exp=0", in_ready); end
    checks++; if (out1_data !== 32'hC0000001) begin errors++; $display("FAIL full_head got=%0h exp=c0000001", out1_data); end
    if (in_ready) exp1.push_back(in_data);
    tick();
    in_valid = 1'b0; out1_ready = 1'b0;
    @(negedge clk);
    checks++; if (out1_valid !== 1'b1) begin errors++; $display("FAIL full_after_v1 got=%0b exp=1", out1_valid); end
    checks++; if (out1_data !== 32'hC0000002) begin errors++; $display("FAIL full_after_d1 got=%0h exp=c0000002", out1_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_after_ready got=%0b exp=1", in_ready); end
    tick();
    out1_ready = 1'b1;
    tick();
    out1_ready = 1'b0;
    @(negedge clk);
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL full_count1 got=%0b exp=0", out1_valid); end
    checks++; if (obs1.size() !== exp1.size()) begin errors++; $display("FAIL full_count got=%0d exp=%0d", obs1.size(), exp1.size()); end
    while (exp1.size() > 0 && obs1.size() > 0) begin
      logic [DW-1:0] e, o;
      e = exp1.pop_front(); o = obs1.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL full_sb1 got=%0h exp=%0h", o, e); end
    end
    exp1.delete(); obs1.delete();
  endtask

  task automatic test_reset_mid();
    out1_ready = 1'b0; out2_ready = 1'b0;
    obs1.delete(); obs2.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      in_valid = 1'b1; in_select = (i >= 2); in_data = 32'hD0000000 + i;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_fill%0d got=%0b exp=1", i, in_ready); end
    end
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL rmid_v1 got=%0b exp=0", out1_valid); end
    checks++; if (out2_valid !== 1'b0) begin errors++; $display("FAIL rmid_v2 got=%0b exp=0", out2_valid); end
    checks++; if (out1_data !== '0) begin errors++; $display("FAIL rmid_d1 got=%0h exp=0", out1_data); end
    checks++; if (out2_data !== '0) begin errors++; $display("FAIL rmid_d2 got=%0h exp=0", out2_data); end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    out1_ready = 1'b1; out2_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (obs1.size() !== 0) begin errors++; $display("FAIL rmid_stale1 got=%0d exp=0", obs1.size()); end
    checks++; if (obs2.size() !== 0) begin errors++; $display("FAIL rmid_stale2 got=%0d exp=0", obs2.size()); end
    checks++; if ((out1_valid | out2_valid) !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%0b exp=0", out1_valid | out2_valid); end
    obs1.delete(); obs2.delete();
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_stats();
    int t;
    out1_ready = 1'b1; out2_ready = 1'b1;
    checks++; if (out1_beats !== 16'd0) begin errors++; $display("FAIL stats_rst1 got=%0d exp=0", out1_beats); end
    for (int i = 0; i < 8; i++) begin
      tick();
      in_valid = 1'b1; in_select = (i >= 5); in_data = 32'hE0000000 + i;
    end
    tick();
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out1_beats !== 16'd5) begin errors++; $display("FAIL stats_out1 got=%0d exp=5", out1_beats); end
    checks++; if (out2_beats !== 16'd3) begin errors++; $display("FAIL stats_out2 got=%0d exp=3", out2_beats); end
    mon_en = 1'b0;
    tick();
    in_valid = 1'b1; in_select = 1'b0; in_data = 32'hE1000000;
    t = 0;
    while (out1_beats !== 16'hFFFF && t < 70000) begin @(negedge clk); t++; end
    checks++; if (out1_beats !== 16'hFFFF) begin errors++; $display("FAIL stats_reach_sat got=%0h exp=ffff", out1_beats); end
    repeat (3) @(negedge clk);
    checks++; if (out1_beats !== 16'hFFFF) begin errors++; $display("FAIL stats_saturate got=%0h exp=ffff", out1_beats); end
    checks++; if (out2_beats !== 16'd3) begin errors++; $display("FAIL stats_out2_hold got=%0d exp=3", out2_beats); end
    tick();
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    obs1.delete(); obs2.delete(); exp1.delete(); exp2.delete();
    mon_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_stream();
    test_full_pop();
    test_reset_mid();
`ifdef DEMUX_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
